// File: rtl/button_pio_debounced.sv
// -----------------------------------------------------------------------------
// button_pio_debounced
//
// Purpose:
//   A WIDTH-channel Avalon-MM input port for board push-buttons and switches.
//   Each raw input passes through a 2-flop synchroniser and then a
//   tick-sampled debounce filter. The filtered level ("stable") can be read
//   back. Each channel has a programmable edge mode (off/rising/falling/any),
//   a sticky edge-capture bit and an interrupt mask. irq is the OR of the
//   masked capture bits.
//
// Optional feature (macro BUTTON_PIO_BITCLEAR_EN):
//   defined   : a write to address 3 clears only the capture bits whose
//               writedata bit is 1 (write-1-to-clear).
//   undefined : any write to address 3 clears every capture bit (legacy).
//   In both builds, a qualified edge in the same cycle as a clear keeps its
//   capture bit set.
//
// Ports:
//   clk         in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   address     in   2      register word address
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data
//   readdata    out  32     registered read data
//   in_port     in   WIDTH  raw asynchronous inputs
//   irq         out  1      level interrupt
//
// Bus protocol: there are no wait states. A write is accepted in any cycle
// where chipselect=1 and write_n=0, and it takes effect from the next cycle.
// readdata is registered every cycle from the register selected by address,
// so it is valid one cycle after address is presented. The read path does not
// depend on chipselect.
//
// Register map (unused upper bits read as 0; writes to them are ignored):
//   0 data         RO  stable[WIDTH-1:0]
//   1 edge_mode    RW  channel i uses bits [2i+1:2i]
//                      00 off, 01 rising, 10 falling, 11 any
//   2 irq_mask     RW  [WIDTH-1:0]
//   3 edge_capture W-clear, otherwise RO
// -----------------------------------------------------------------------------
module button_pio_debounced #(
    parameter int unsigned       WIDTH      = 4,
    parameter int unsigned       TICK_DIV   = 50000,
    parameter int unsigned       DB_SAMPLES = 8,
    parameter logic [WIDTH-1:0]  IDLE_LEVEL = {WIDTH{1'b1}},
    parameter logic [1:0]        MODE_RESET = 2'b10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    localparam int unsigned   PW      = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int unsigned   CW      = (DB_SAMPLES > 1) ? $clog2(DB_SAMPLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_SAMPLES - 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MODE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAPT = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   s1_q;
    logic [WIDTH-1:0]   s2_q;
    logic [WIDTH-1:0]   stable_q,  stable_d;
    logic [PW-1:0]      pre_q,     pre_d;
    logic [CW-1:0]      cnt_q [WIDTH];
    logic [CW-1:0]      cnt_d [WIDTH];
    logic [2*WIDTH-1:0] mode_q,    mode_d;
    logic [WIDTH-1:0]   mask_q,    mask_d;
    logic [WIDTH-1:0]   capt_q,    capt_d;
    logic [31:0]        rdata_q,   rdata_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_en;
    logic wr_mode;
    logic wr_mask;
    logic wr_capt;

    assign wr_en   = chipselect & ~write_n;
    assign wr_mode = wr_en & (address == ADDR_MODE);
    assign wr_mask = wr_en & (address == ADDR_MASK);
    assign wr_capt = wr_en & (address == ADDR_CAPT);

    // Only the low bits of writedata reach any register. The reduction
    // marks the remaining upper bits as intentionally ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // Sample-tick prescaler
    // ------------------------------------------------------------------
    logic tick;

    assign tick = (pre_q == PRE_MAX);

    always_comb begin
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    // ------------------------------------------------------------------
    // Debounce filter. On each tick, a channel whose synchronised input
    // differs from its stable level advances its counter. The DB_SAMPLES-th
    // consecutive differing tick accepts the new level. Any agreeing tick
    // restarts the count, so a glitch shorter than DB_SAMPLES ticks is
    // never seen.
    // ------------------------------------------------------------------
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (s2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = s2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detection and capture. Edges come from the filter's next-state
    // value, so each capture bit is set on the same clock edge as the
    // stable level flips. The mode in force at that moment qualifies
    // the edge. Clear is applied before set, so a simultaneous edge
    // is never lost.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] qual;
    logic [WIDTH-1:0] clr;

    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;

    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            qual[i] = (rise[i] & mode_q[2*i]) | (fall[i] & mode_q[2*i+1]);
        end
    end

`ifdef BUTTON_PIO_BITCLEAR_EN
    assign clr = wr_capt ? writedata[WIDTH-1:0] : '0;
`else
    assign clr = wr_capt ? {WIDTH{1'b1}} : '0;
`endif

    always_comb begin
        capt_d = (capt_q & ~clr) | qual;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_comb begin
        mode_d = mode_q;
        mask_d = mask_q;
        if (wr_mode) begin
            mode_d = writedata[2*WIDTH-1:0];
        end
        if (wr_mask) begin
            mask_d = writedata[WIDTH-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Read mux. The selected register is zero-extended to 32 bits.
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA: rdata_d[WIDTH-1:0]   = stable_q;
            ADDR_MODE: rdata_d[2*WIDTH-1:0] = mode_q;
            ADDR_MASK: rdata_d[WIDTH-1:0]   = mask_q;
            ADDR_CAPT: rdata_d[WIDTH-1:0]   = capt_q;
            default:   rdata_d              = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= IDLE_LEVEL;
            s2_q     <= IDLE_LEVEL;
            stable_q <= IDLE_LEVEL;
            pre_q    <= '0;
            mode_q   <= {WIDTH{MODE_RESET}};
            mask_q   <= '0;
            capt_q   <= '0;
            rdata_q  <= '0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= in_port;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            pre_q    <= pre_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            capt_q   <= capt_d;
            rdata_q  <= rdata_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(capt_q & mask_q);

endmodule

// File: tb/tb_button_pio_debounced.sv
// -----------------------------------------------------------------------------
// Bench for button_pio_debounced with WIDTH=4, TICK_DIV=4, DB_SAMPLES=3.
// A behavioural model counts clock cycles and consecutive differing ticks and
// predicts readdata and irq for every cycle. Directed scenarios add literal
// expectations, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_button_pio_debounced;

  localparam int W  = 4;
  localparam int TD = 4;
  localparam int DB = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = {W{1'b1}};
  logic          irq;

  always #5 clk = ~clk;

  button_pio_debounced #(
    .WIDTH(W), .TICK_DIV(TD), .DB_SAMPLES(DB),
    .IDLE_LEVEL({W{1'b1}}), .MODE_RESET(2'b10)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model applies the register and filter rules at each rising edge,
  // using the inputs that were driven before that edge.
  logic [W-1:0]   m_s1, m_s2, m_stable, m_mask, m_cap;
  logic [2*W-1:0] m_mode;
  logic [31:0]    m_rd;
  int             m_cyc;       // cycles since reset was released
  int             m_run [W];   // consecutive ticks with the input differing from stable
  logic [W-1:0]   nxt, ev, clr;
  bit             m_tick;
  logic [32:0]    exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_stable = '1;
      m_mode = 8'hAA; m_mask = '0; m_cap = '0; m_rd = '0; m_cyc = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      case (address)
        2'd0: m_rd = {28'd0, m_stable};
        2'd1: m_rd = {24'd0, m_mode};
        2'd2: m_rd = {28'd0, m_mask};
        default: m_rd = {28'd0, m_cap};
      endcase
      m_tick = ((m_cyc % TD) == TD - 1);
      m_cyc++;
      nxt = m_stable;
      if (m_tick) begin
        for (int i = 0; i < W; i++) begin
          if (m_s2[i] != m_stable[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
              nxt[i] = m_s2[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      ev = '0;
      for (int i = 0; i < W; i++) begin
        if (nxt[i] && !m_stable[i] && (m_mode[2*i] == 1'b1)) ev[i] = 1'b1;
        if (!nxt[i] && m_stable[i] && (m_mode[2*i+1] == 1'b1)) ev[i] = 1'b1;
      end
      clr = '0;
      if (chipselect && !write_n && address == 2'd3) begin
`ifdef BUTTON_PIO_BITCLEAR_EN
        clr = writedata[W-1:0];
`else
        clr = '1;
`endif
      end
      m_cap = (m_cap & ~clr) | ev;
      if (chipselect && !write_n && address == 2'd1) m_mode = writedata[2*W-1:0];
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_stable = nxt;
      m_s2 = m_s1;
      m_s1 = in_port;
    end
    exp_q.push_back({|(m_cap & m_mask), m_rd});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("readdata", readdata, e[31:0]);
      check("irq", {31'd0, irq}, {31'd0, e[32]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d;
    bit aligned;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset values
    read_check("rst_data", 2'd0, 32'hF);
    read_check("rst_mode", 2'd1, 32'hAA);
    read_check("rst_mask", 2'd2, 32'h0);
    read_check("rst_capt", 2'd3, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // 2: ch0 held low
    bus_write(2'd2, 32'h1);
    in_port = 4'hE;
    wait_cycles(20);
    read_check("ch0_data", 2'd0, 32'hE);
    read_check("ch0_capt", 2'd3, 32'h1);
    check("ch0_irq", {31'd0, irq}, 32'd1);

    // 3: two-tick glitch on ch1 is filtered out
    bus_write(2'd3, 32'hF);
    @(negedge clk);
    in_port = 4'hC;
    wait_cycles(2 * TD);
    in_port = 4'hE;
    wait_cycles(20);
    read_check("glitch_data", 2'd0, 32'hE);
    read_check("glitch_capt", 2'd3, 32'h0);
    check("glitch_irq", {31'd0, irq}, 32'd0);

    // 4: ch1 any-edge mode, ch2 off
    bus_write(2'd1, 32'h0000000C);
    in_port = 4'hC;
    wait_cycles(20);
    read_check("any_fall", 2'd3, 32'h2);
    bus_write(2'd3, 32'hF);
    in_port = 4'hE;
    wait_cycles(20);
    read_check("any_rise", 2'd3, 32'h2);
    bus_write(2'd3, 32'hF);
    in_port = 4'hA;
    wait_cycles(20);
    read_check("off_data", 2'd0, 32'hA);
    read_check("off_capt", 2'd3, 32'h0);
    in_port = 4'hE;
    wait_cycles(20);

    // 5: partial clear
    bus_write(2'd1, 32'h000000FF);
    in_port = 4'hD;
    wait_cycles(20);
    read_check("two_capt", 2'd3, 32'h3);
    bus_write(2'd3, 32'h1);
`ifdef BUTTON_PIO_BITCLEAR_EN
    read_check("bitclear", 2'd3, 32'h2);
`else
    read_check("legacy_clear", 2'd3, 32'h0);
`endif

    // 6: clear in the same cycle as a qualified falling edge on ch0
    bus_write(2'd1, 32'h000000AA);
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'hF);
    in_port = 4'hC;
    aligned = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (((m_cyc % TD) == TD - 1) && (m_run[0] == DB - 1) && (m_s2[0] != m_stable[0])) begin
        aligned = 1'b1;
        break;
      end
    end
    check("align_found", {31'd0, aligned}, 32'd1);
    address = 2'd3; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    check("setwins_irq", {31'd0, irq}, 32'd1);
    read_check("setwins_capt", 2'd3, 32'h1);

    // 7: randomized traffic, including resets during debounce
    for (int n = 0; n < 3000; n++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 999);
      reset = (r < 5);
      if ($urandom_range(0, 99) < 4) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      address = 2'($urandom_range(0, 3));
      chipselect = ($urandom_range(0, 3) != 0);
      write_n = ($urandom_range(0, 9) != 0);
      writedata = $urandom;
    end
    @(negedge clk);
    reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    wait_cycles(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
